// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control and status bundle for the loadable down-counter.
interface countdown_timer_if #(
    parameter int WIDTH = 12
);
    logic             i_load;
    logic [WIDTH-1:0] i_load_value;
    logic             i_mode;
    logic             i_en;
    logic             i_clear;
    logic [WIDTH-1:0] o_count;
    logic             o_expired;
    logic             o_busy;
    modport master (
        output i_load, i_load_value, i_mode, i_en, i_clear,
        input  o_count, o_expired, o_busy
    );
    modport slave (
        input  i_load, i_load_value, i_mode, i_en, i_clear,
        output o_count, o_expired, o_busy
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot/periodic terminal-count pulse.
module countdown_timer #(
    parameter int WIDTH = 12
) (
    input logic               i_clk,
    input logic               i_rst,
    countdown_timer_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] count;
    logic             expired;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            reload  <= '0;
            count   <= '0;
            expired <= 1'b0;
        end else if (bus.i_clear) begin
            state   <= IDLE;
            count   <= '0;
            expired <= 1'b0;
        end else if (bus.i_load) begin
            reload  <= bus.i_load_value;
            count   <= bus.i_load_value;
            state   <= (bus.i_load_value != '0) ? RUN : IDLE;
            expired <= 1'b0;
        end else if (state == RUN && bus.i_en) begin
            // Terminal count: reload in periodic mode, otherwise stop at zero
            if (count == WIDTH'(1)) begin
                expired <= 1'b1;
                count   <= bus.i_mode ? reload : '0;
                state   <= bus.i_mode ? RUN : IDLE;
            end else begin
                count   <= count - WIDTH'(1);
                expired <= 1'b0;
            end
        end else begin
            expired <= 1'b0;
        end
    end
    assign bus.o_count   = count;
    assign bus.o_expired = expired;
    assign bus.o_busy    = (state == RUN);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed plus random stimulus, period/elapsed reference model, queued scoreboard.
module tb_countdown_timer;
    localparam int W = 12;
    typedef struct packed {
        logic [W-1:0] count;
        logic         expired;
        logic         busy;
    } exp_t;
    logic dut_clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q[$];
    exp_t e;
    // Reference model: time since the current period began, rather than a count register
    int   m_reload  = 0;
    int   m_elapsed = 0;
    bit   m_run     = 0;
    countdown_timer_if #(.WIDTH(W)) bus ();
    countdown_timer #(.WIDTH(W)) dut (
        .i_clk (dut_clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );
    always #5 dut_clk = ~dut_clk;
    task automatic step(input bit r, input bit c, input bit l, input int v, input bit m, input bit en);
        exp_t x;
        bit   pulse;
        @(negedge dut_clk);
        rst              = r;
        bus.i_clear      = c;
        bus.i_load       = l;
        bus.i_load_value = W'(v);
        bus.i_mode       = m;
        bus.i_en         = en;
        pulse = 0;
        if (r) begin
            m_reload = 0; m_run = 0; m_elapsed = 0;
        end else if (c) begin
            m_run = 0; m_elapsed = 0;
        end else if (l) begin
            m_reload = v; m_elapsed = 0; m_run = (v != 0);
        end else if (m_run && en) begin
            m_elapsed++;
            if (m_elapsed == m_reload) begin
                pulse = 1;
                m_elapsed = 0;
                if (!m) m_run = 0;
            end
        end
        x.count   = m_run ? W'(m_reload - m_elapsed) : '0;
        x.expired = pulse;
        x.busy    = m_run;
        q.push_back(x);
    endtask
    task automatic run_en(input int n, input bit m, input bit en);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, m, en);
    endtask
    always @(posedge dut_clk) begin
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (bus.o_count !== e.count) begin
                fails++;
                $display("FAIL count cyc %0d: got %0d expected %0d", cyc, bus.o_count, e.count);
            end
            tests++;
            if (bus.o_expired !== e.expired) begin
                fails++;
                $display("FAIL expired cyc %0d: got %0b expected %0b", cyc, bus.o_expired, e.expired);
            end
            tests++;
            if (bus.o_busy !== e.busy) begin
                fails++;
                $display("FAIL busy cyc %0d: got %0b expected %0b", cyc, bus.o_busy, e.busy);
            end
        end
    end
    initial begin
        rst = 1; bus.i_clear = 0; bus.i_load = 0; bus.i_load_value = '0; bus.i_mode = 0; bus.i_en = 0;
        for (int i = 0; i < 16; i++) step(1, 0, 1, 7, 0, 1);
        step(0, 0, 1, 10, 0, 1);
        run_en(21, 0, 1);
        step(0, 0, 1, 4, 1, 1);
        run_en(12, 1, 1);
        run_en(10, 1, 0);
        step(0, 0, 1, 20, 0, 1);
        run_en(5, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        run_en(4, 0, 1);
        step(0, 0, 1, 1, 1, 1);
        run_en(6, 1, 1);
        step(0, 0, 1, 0, 1, 1);
        run_en(3, 1, 1);
        step(0, 0, 1, 4095, 0, 1);
        run_en(4100, 0, 1);
        step(0, 0, 1, 3, 0, 1);
        run_en(2, 0, 1);
        step(0, 0, 1, 9, 0, 1);
        run_en(3, 0, 1);
        step(0, 1, 1, 9, 0, 1);
        run_en(2, 0, 1);
        step(0, 0, 1, 6, 1, 1);
        run_en(2, 1, 1);
        step(1, 1, 0, 0, 1, 1);
        run_en(2, 1, 1);
        step(0, 0, 1, 5, 1, 1);
        run_en(3, 1, 1);
        run_en(4, 0, 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 19) == 0,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 8)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
        @(posedge dut_clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter that decrements from a programmed value and flags terminal count. It is the decrementing counterpart to the team's up-counter.
- Used as a programmable tick/timeout generator in either one-shot or periodic mode.
- Sits beside control FSMs that need delays, watchdogs or rate strobes. It shares the up-counter's enable/clear control style.

Parameters:
- WIDTH, 12, bit width of the count, the load value and the reload register.

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_load  in  1  single-cycle strobe: capture i_load_value into the count and reload registers.
- i_load_value  in  WIDTH  start/reload value; sampled only when i_load=1.
- i_mode  in  1  0 = one-shot, 1 = periodic; sampled at terminal count.
- i_en  in  1  count enable; when low, the count holds.
- i_clear  in  1  abort: count to 0, return to IDLE.
- o_count  out  WIDTH  current count (registered).
- o_expired  out  1  one-cycle pulse on terminal count (registered).
- o_busy  out  1  high while in RUN.

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: o_count=0, o_expired=0, o_busy=0, reload register=0, state=IDLE.
- States: IDLE, RUN. o_busy is high exactly when state=RUN, with no combinational path from inputs.
- Priority per edge: i_rst > i_clear > i_load > counting.
- i_clear (any state):
  - o_count<=0, state<=IDLE, o_expired<=0.
  - Reload register is retained.
- i_load (any state, no clear):
  - Reload register and o_count both take i_load_value.
  - If i_load_value != 0, state<=RUN; if i_load_value == 0, state<=IDLE.
  - o_expired<=0, including when a load lands on a cycle that would otherwise terminate.
  - A load in RUN restarts the count immediately, with no pulse.
- RUN, i_en=0: o_count holds, o_expired<=0.
- RUN, i_en=1, o_count>1: o_count<=o_count-1, o_expired<=0.
- RUN, i_en=1, o_count==1 (terminal count), o_expired<=1 on the same edge:
  - i_mode=0: o_count<=0, state<=IDLE.
  - i_mode=1: o_count<=reload register, state stays RUN.
- Terminal-count timing: after a load of N with i_en held high, o_expired is high during the N-th cycle following the load edge.
  - Periodic mode then pulses once every N enabled cycles.
  - Reload=1 in periodic mode pulses every enabled cycle, with o_count constant at 1.
- IDLE: o_count holds (0 after expiry or clear; held at the loaded value only for a load of 0, which is 0). i_en is ignored and o_expired=0.
- Arithmetic: unsigned, WIDTH bits. The count never decrements below 0 and never wraps.
- Width boundary: a load of 2^WIDTH-1 (4095 at default) counts the full range.
- Mode changes mid-count take effect only at the next terminal count.
- Reset mid-count: all outputs return to reset values on the next edge, with no pulse.

Test Plan:
- Reset check: i_rst=1 for 16 cycles with i_load=1, i_load_value=7, i_en=1 -> o_count=0, o_busy=0, o_expired never high.
- One-shot: load 10, i_mode=0, i_en=1 -> o_count steps 10..1,0; exactly one o_expired pulse on the edge o_count becomes 0; o_busy falls on the same edge; o_count stays 0 for 10 more cycles.
- Periodic + hold: load 4, i_mode=1, i_en=1 for 12 cycles -> 3 pulses, 4 cycles apart, o_count pattern 4,3,2,1,4... Then i_en=0 for 10 cycles -> o_count frozen, no pulses.
- Clear mid-count: load 20, run 5 cycles (o_count=15), pulse i_clear -> o_count=0, o_busy=0, no pulse. Next: i_en=1 alone -> o_count stays 0.
- Reload boundary: load 1, i_mode=1, i_en=1 -> o_expired high every cycle, o_count=1. Load 0 -> o_busy=0, o_count=0, no pulse. Load 4095 with i_mode=0 -> single pulse after 4095 enabled cycles.
- Simultaneous events:
  - At o_count=1 with i_en=1, assert i_load=9 -> no pulse, o_count=9.
  - Assert i_clear and i_load together -> clear wins, o_count=0.
  - Assert i_rst and i_clear together -> reset values.
